// File: rtl/attention_scheduler.sv
// Sequences the five matmul phases (Q, K, V, S, Z) of one attention head on an external engine.
// Problem dimensions are fetched from word 0 of the input and weight SRAMs at job start.
module attention_scheduler (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        dut_valid,
  output logic        dut_ready,
  output logic [15:0] dut__tb__sram_input_read_address,
  input  logic [31:0] tb__dut__sram_input_read_data,
  output logic [15:0] dut__tb__sram_weight_read_address,
  input  logic [31:0] tb__dut__sram_weight_read_data,
  output logic        eng_start,
  output logic [2:0]  eng_op,
  output logic [15:0] eng_rows,
  output logic [15:0] eng_inner,
  output logic [15:0] eng_cols,
  output logic [15:0] eng_a_base,
  output logic [15:0] eng_b_base,
  output logic [15:0] eng_c_base,
  output logic        eng_a_src,
  output logic        eng_b_src,
  output logic        eng_b_transpose,
  input  logic        eng_done,
  output logic        error
);

  // Handshake: a job is accepted on any rising edge where dut_valid=1 and dut_ready=1;
  // dut_ready stays low until the job (or its dimension error) has completed.
  typedef enum logic [2:0] {
    S_IDLE, S_DIM_REQ, S_DIM_CAP, S_CALC, S_ISSUE, S_WAIT, S_DONE
  } state_t;

  state_t      state, state_next;
  logic [2:0]  phase, phase_next;
  logic        load_cfg;
  logic        dim_err;
  logic [15:0] dim_n, dim_d, dim_wr, dim_wc;
  logic [15:0] dd, nd, nn;

  // Dimensions always live at word 0, so the read address never leaves zero.
  assign dut__tb__sram_input_read_address  = 16'd0;
  assign dut__tb__sram_weight_read_address = 16'd0;

  assign dut_ready = (state == S_IDLE);
  assign eng_start = (state == S_ISSUE);
  assign dim_err   = (dim_n == 16'd0) || (dim_d == 16'd0) ||
                     (dim_wr != dim_d) || (dim_wc != dim_d);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      phase <= 3'd0;
    end else begin
      state <= state_next;
      phase <= phase_next;
    end
  end

  always_comb begin
    state_next = state;
    phase_next = phase;
    load_cfg   = 1'b0;
    case (state)
      S_IDLE:    if (dut_valid) state_next = S_DIM_REQ;
      S_DIM_REQ: state_next = S_DIM_CAP;
      S_DIM_CAP: state_next = S_CALC;
      S_CALC: begin
        phase_next = 3'd0;
        if (dim_err) begin
          state_next = S_DONE;
        end else begin
          state_next = S_ISSUE;
          load_cfg   = 1'b1;
        end
      end
      S_ISSUE:   state_next = S_WAIT;
      S_WAIT: begin
        if (eng_done) begin
          if (phase == 3'd4) begin
            state_next = S_DONE;
          end else begin
            phase_next = 3'(phase + 3'd1);
            state_next = S_ISSUE;
            load_cfg   = 1'b1;
          end
        end
      end
      S_DONE:    state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dim_n <= '0; dim_d <= '0; dim_wr <= '0; dim_wc <= '0;
      dd <= '0; nd <= '0; nn <= '0;
      error <= 1'b0;
      eng_op <= '0; eng_rows <= '0; eng_inner <= '0; eng_cols <= '0;
      eng_a_base <= '0; eng_b_base <= '0; eng_c_base <= '0;
      eng_a_src <= 1'b0; eng_b_src <= 1'b0; eng_b_transpose <= 1'b0;
    end else begin
      if (state == S_IDLE && dut_valid) error <= 1'b0;
      if (state == S_DIM_CAP) begin
        dim_n  <= tb__dut__sram_input_read_data[31:16];
        dim_d  <= tb__dut__sram_input_read_data[15:0];
        dim_wr <= tb__dut__sram_weight_read_data[31:16];
        dim_wc <= tb__dut__sram_weight_read_data[15:0];
      end
      if (state == S_CALC) begin
        dd <= dim_d * dim_d;
        nd <= dim_n * dim_d;
        nn <= dim_n * dim_n;
        if (dim_err) error <= 1'b1;
      end
      // Q only needs N and D, so it can load while the products are still being registered.
      if (load_cfg) begin
        eng_op <= phase_next;
        case (phase_next)
          3'd0: begin
            eng_rows <= dim_n; eng_inner <= dim_d; eng_cols <= dim_d;
            eng_a_base <= 16'd1; eng_b_base <= 16'd1; eng_c_base <= 16'd0;
            eng_a_src <= 1'b0; eng_b_src <= 1'b0; eng_b_transpose <= 1'b0;
          end
          3'd1: begin
            eng_rows <= dim_n; eng_inner <= dim_d; eng_cols <= dim_d;
            eng_a_base <= 16'd1; eng_b_base <= 16'd1 + dd; eng_c_base <= nd;
            eng_a_src <= 1'b0; eng_b_src <= 1'b0; eng_b_transpose <= 1'b0;
          end
          3'd2: begin
            eng_rows <= dim_n; eng_inner <= dim_d; eng_cols <= dim_d;
            eng_a_base <= 16'd1; eng_b_base <= 16'd1 + dd + dd; eng_c_base <= nd + nd;
            eng_a_src <= 1'b0; eng_b_src <= 1'b0; eng_b_transpose <= 1'b0;
          end
          3'd3: begin
            eng_rows <= dim_n; eng_inner <= dim_d; eng_cols <= dim_n;
            eng_a_base <= 16'd0; eng_b_base <= nd; eng_c_base <= nd + nd + nd;
            eng_a_src <= 1'b1; eng_b_src <= 1'b1; eng_b_transpose <= 1'b1;
          end
          default: begin
            eng_rows <= dim_n; eng_inner <= dim_n; eng_cols <= dim_d;
            eng_a_base <= nd + nd + nd; eng_b_base <= nd + nd; eng_c_base <= nd + nd + nd + nn;
            eng_a_src <= 1'b1; eng_b_src <= 1'b1; eng_b_transpose <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
